// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and state encoding for the UART frame receiver.
package uart_frame_rx_pkg;

  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [31:0] DEFAULT_MAGIC = 32'hDABBAD00;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC_HI  = 2'd2,
    ST_CRC_LO  = 2'd3
  } state_t;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte CRC-16/CCITT-FALSE update (MSB first); purely combinational.
// No state, no flow control: the result is valid in the same cycle as the inputs.
module crc16_ccitt_byte
  import uart_frame_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frames a UART byte stream: sliding header hunt, fixed payload, CRC-16 check; result pulses one cycle after the last CRC byte.
// Never stalls: a byte is accepted on every rx_data_ready strobe, including back-to-back strobes.
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter logic [31:0] MAGIC          = DEFAULT_MAGIC,
  parameter int          HEADER_BYTES   = 4,
  parameter int          PAYLOAD_BYTES  = 16,
  parameter int          TIMEOUT_CYCLES = 16000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         rx_data_ready,
  input  logic [7:0]                   rx_data,
  output logic                         frame_valid,
  output logic [PAYLOAD_BYTES*8-1:0]   frame_data,
  output logic                         crc_error,
  output logic                         timeout_error,
  output logic                         busy
);

  localparam int HW    = HEADER_BYTES * 8;
  localparam int CNT_W = 7;
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HW-1:0]    HDR      = MAGIC[HW-1:0];
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  state_t                     state;
  logic [HW-1:0]              hist;
  logic [HW-1:0]              hist_next;
  logic [CNT_W-1:0]           byte_cnt;
  logic [GAP_W-1:0]           gap_cnt;
  logic [15:0]                crc_reg;
  logic [15:0]                crc_next;
  logic [7:0]                 crc_hi;
  logic [PAYLOAD_BYTES*8-1:0] pay_buf;

  if (HEADER_BYTES == 1) begin : g_hist_1
    assign hist_next = rx_data;
  end else begin : g_hist_n
    assign hist_next = {hist[HW-9:0], rx_data};
  end

  crc16_ccitt_byte u_crc (
    .crc_in  (crc_reg),
    .data    (rx_data),
    .crc_out (crc_next)
  );

  assign busy = (state != ST_HUNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_HUNT;
      hist          <= '0;
      byte_cnt      <= '0;
      gap_cnt       <= '0;
      crc_reg       <= CRC_INIT;
      crc_hi        <= '0;
      pay_buf       <= '0;
      frame_data    <= '0;
      frame_valid   <= 1'b0;
      crc_error     <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      frame_valid   <= 1'b0;
      crc_error     <= 1'b0;
      timeout_error <= 1'b0;
      if (state == ST_HUNT) begin
        if (rx_data_ready) begin
          hist <= hist_next;
          if (hist_next == HDR) begin
            state    <= ST_PAYLOAD;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            crc_reg  <= CRC_INIT;
          end
        end
      end else if (rx_data_ready) begin
        // A strobe on the terminal gap count still wins over the timeout.
        gap_cnt <= '0;
        case (state)
          ST_PAYLOAD: begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
              if (byte_cnt == CNT_W'(i)) pay_buf[i*8 +: 8] <= rx_data;
            end
            crc_reg  <= crc_next;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_IDX) state <= ST_CRC_HI;
          end
          ST_CRC_HI: begin
            crc_hi <= rx_data;
            state  <= ST_CRC_LO;
          end
          ST_CRC_LO: begin
            if ({crc_hi, rx_data} == crc_reg) begin
              frame_valid <= 1'b1;
              frame_data  <= pay_buf;
            end else begin
              crc_error <= 1'b1;
            end
            state <= ST_HUNT;
            hist  <= '0;
          end
          default: state <= ST_HUNT;
        endcase
      end else if (gap_cnt == GAP_LAST) begin
        timeout_error <= 1'b1;
        state         <= ST_HUNT;
        hist          <= '0;
        gap_cnt       <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a 9-byte payload and a 100-cycle gap timeout.
module tb_uart_frame_rx;

  localparam logic [71:0] GOOD = 72'h393837363534333231;

  logic        CLK = 1'b0;
  logic        RST;
  logic        rx_data_ready;
  logic [7:0]  rx_data;
  logic        frame_valid;
  logic [71:0] frame_data;
  logic        crc_error;
  logic        timeout_error;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt_valid = 0, cnt_crc = 0, cnt_to = 0;
  int valid_cyc_last = 0, valid_cyc_prev = 0;
  int s_valid, s_crc, s_to;

  logic [7:0] frm [0:14];

  uart_frame_rx #(
    .MAGIC          (32'hDABBAD00),
    .HEADER_BYTES   (4),
    .PAYLOAD_BYTES  (9),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .crc_error     (crc_error),
    .timeout_error (timeout_error),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse bookkeeping plus the one-hot rule on the three result pulses.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (frame_valid === 1'b1) begin
        cnt_valid++;
        valid_cyc_prev = valid_cyc_last;
        valid_cyc_last = cyc;
      end
      if (crc_error === 1'b1) cnt_crc++;
      if (timeout_error === 1'b1) cnt_to++;
      if ((frame_valid | crc_error | timeout_error) === 1'b1)
        check("pulse_onehot", 72'(frame_valid + crc_error + timeout_error), 72'd1);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data_ready = 1'b1;
    rx_data       = b;
    @(negedge CLK);
    rx_data_ready = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(frm[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic snap();
    s_valid = cnt_valid;
    s_crc   = cnt_crc;
    s_to    = cnt_to;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    frm = '{8'hDA, 8'hBB, 8'hAD, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34,
            8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    RST = 1'b1;
    rx_data_ready = 1'b0;
    rx_data = 8'h00;
    idle(2);
    check("rst_valid", 72'(frame_valid), 72'd0);
    check("rst_crc_err", 72'(crc_error), 72'd0);
    check("rst_timeout", 72'(timeout_error), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_data", frame_data, 72'd0);
    RST = 1'b0;
    idle(1);

    // Good frame
    send_range(0, 14);
    check("good_valid", 72'(frame_valid), 72'd1);
    check("good_crc_err", 72'(crc_error), 72'd0);
    check("good_data", frame_data, GOOD);
    idle(1);
    check("good_valid_pulse", 72'(frame_valid), 72'd0);
    check("good_busy_after", 72'(busy), 72'd0);

    // Corrupted CRC low byte
    send_range(0, 13);
    send(8'hB2);
    check("bad_crc_err", 72'(crc_error), 72'd1);
    check("bad_valid", 72'(frame_valid), 72'd0);
    check("bad_data_held", frame_data, GOOD);
    idle(1);
    check("bad_crc_pulse", 72'(crc_error), 72'd0);

    // Reset after six bytes, then resend the whole frame
    snap();
    send_range(0, 5);
    check("mid_busy", 72'(busy), 72'd1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("mid_rst_busy", 72'(busy), 72'd0);
    check("mid_rst_data", frame_data, 72'd0);
    send_range(0, 14);
    idle(2);
    check("mid_valid_cnt", 72'(cnt_valid - s_valid), 72'd1);
    check("mid_crc_cnt", 72'(cnt_crc - s_crc), 72'd0);
    check("mid_to_cnt", 72'(cnt_to - s_to), 72'd0);
    check("mid_data", frame_data, GOOD);

    // Misaligned header with leading garbage, starting from cleared frame_data
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("mis_rst_data", frame_data, 72'd0);
    send(8'h11);
    send(8'hDA);
    send_range(0, 14);
    check("mis_valid", 72'(frame_valid), 72'd1);
    check("mis_data", frame_data, GOOD);
    idle(1);

    // Strobe landing exactly on the terminal gap count is accepted
    snap();
    send_range(0, 6);
    idle(99);
    send(frm[7]);
    check("tc_no_timeout", 72'(timeout_error), 72'd0);
    check("tc_busy", 72'(busy), 72'd1);
    send_range(8, 14);
    check("tc_valid", 72'(frame_valid), 72'd1);
    check("tc_data", frame_data, GOOD);
    idle(1);
    check("tc_to_cnt", 72'(cnt_to - s_to), 72'd0);

    // Gap timeout after header plus three payload bytes
    snap();
    send_range(0, 6);
    idle(99);
    check("to_early", 72'(timeout_error), 72'd0);
    check("to_busy_before", 72'(busy), 72'd1);
    idle(1);
    check("to_pulse", 72'(timeout_error), 72'd1);
    check("to_busy_after", 72'(busy), 72'd0);
    idle(1);
    check("to_pulse_end", 72'(timeout_error), 72'd0);
    check("to_cnt", 72'(cnt_to - s_to), 72'd1);
    send_range(0, 14);
    check("to_next_valid", 72'(frame_valid), 72'd1);
    idle(1);

    // Two frames back-to-back with a strobe on every cycle
    snap();
    send_range(0, 14);
    send_range(0, 14);
    check("b2b_second_valid", 72'(frame_valid), 72'd1);
    idle(1);
    check("b2b_valid_cnt", 72'(cnt_valid - s_valid), 72'd2);
    check("b2b_spacing", 72'(valid_cyc_last - valid_cyc_prev), 72'd15);
    check("b2b_crc_cnt", 72'(cnt_crc - s_crc), 72'd0);
    check("b2b_data", frame_data, GOOD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter MAGIC, default 32'hDABBAD00, header pattern; the first header byte on the wire is MAGIC[31:24].
REQ-002 Parameter HEADER_BYTES, default 4, header length in bytes; legal range 1..4; the lowest HEADER_BYTES bytes of MAGIC are used.
REQ-003 Parameter PAYLOAD_BYTES, default 16, payload length in bytes; legal range 1..64.
REQ-004 Parameter TIMEOUT_CYCLES, default 16000, maximum inter-byte gap inside a frame (1 ms at 16 MHz).
REQ-005 Port CLK, input, 1 bit: the single clock, 16 MHz.
REQ-006 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port rx_data_ready, input, 1 bit: one-cycle strobe from uart_rx that a byte is available.
REQ-008 Port rx_data, input, 8 bits: received byte, valid while rx_data_ready is high.
REQ-009 Port frame_valid, output, 1 bit: one-cycle pulse marking a good frame.
REQ-010 Port frame_data, output, PAYLOAD_BYTES*8 bits: payload with byte 0 (first received) in bits [7:0].
REQ-011 Port crc_error, output, 1 bit: one-cycle pulse marking a CRC mismatch.
REQ-012 Port timeout_error, output, 1 bit: one-cycle pulse marking an inter-byte gap timeout.
REQ-013 Port busy, output, 1 bit: high in any state other than HUNT.

Function
REQ-014 States SHALL be HUNT, PAYLOAD, CRC_HI and CRC_LO.
- HUNT to PAYLOAD on header match.
- PAYLOAD to CRC_HI after the PAYLOAD_BYTES-th byte.
- CRC_HI to CRC_LO after one byte.
- CRC_LO to HUNT after one byte.
- Any state other than HUNT goes to HUNT on timeout.
REQ-015 In HUNT, each strobed byte SHALL shift into a HEADER_BYTES-deep history register; a match SHALL be declared on the strobe whose byte completes the history equal to the header.
REQ-016 Header matching SHALL be sliding: any byte alignment is accepted, and leading garbage is ignored.
REQ-017 The byte counter SHALL reset to 0 on entry to PAYLOAD, and each payload byte SHALL be written to slot [counter].
REQ-018 CRC SHALL be CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no xorout), computed over payload bytes only, one byte per strobe.
REQ-019 The received CRC SHALL be two bytes, high byte first.
REQ-020 Frame result latency:
- On the CRC_LO strobe, {crc_hi, rx_data} SHALL be compared with the running CRC.
- In the next cycle, exactly one of frame_valid or crc_error SHALL pulse.
REQ-021 frame_data SHALL update only together with frame_valid and SHALL hold its value otherwise; a bad frame SHALL NOT alter it.
REQ-022 The gap counter SHALL clear on every strobe and on entry to PAYLOAD.
- In a non-HUNT state, if the counter reaches TIMEOUT_CYCLES-1 with no strobe, timeout_error SHALL pulse the next cycle and the state SHALL return to HUNT.
- The counter SHALL NOT increment in HUNT.
REQ-023 On every entry to HUNT the history register SHALL clear to 0, so bytes of a finished or aborted frame never count toward a header.
REQ-024 A strobe arriving in the same cycle as the timeout terminal count SHALL win: the byte is accepted and no timeout occurs.
REQ-025 Strobes SHALL be accepted on consecutive cycles; the block SHALL never stall or drop a strobed byte.
REQ-026 frame_valid, crc_error and timeout_error SHALL be mutually exclusive in any cycle.

Reset
REQ-027 While RST is high on a clock edge, the following SHALL be forced:
- state = HUNT;
- history, byte counter and gap counter = 0;
- CRC register = 0xFFFF;
- all pulse outputs = 0;
- busy = 0;
- frame_data = 0.
REQ-028 RST asserted mid-frame SHALL discard the partial frame with no error pulse; the first byte after release SHALL be treated as a HUNT byte.

Structure
REQ-029 A shared package SHALL hold:
- the CRC polynomial 16'h1021 and init value 16'hFFFF;
- the state encoding;
- the default MAGIC.
REQ-030 One sub-module, crc16_ccitt_byte, SHALL be used: combinational, inputs crc_in[15:0] and data[7:0], output crc_out[15:0].
REQ-031 The implementation SHALL be 120-400 lines of RTL with no memories inferred beyond the registers.

Verification
REQ-032 Good frame, PAYLOAD_BYTES=9: stimulus DA BB AD 00 31 32 33 34 35 36 37 38 39 29 B1 -> frame_valid one cycle after the final strobe; frame_data = 72'h393837363534333231.
REQ-033 Corrupt CRC: same frame with final byte B2 -> crc_error pulse, no frame_valid, frame_data unchanged from its previous value.
REQ-034 Misaligned header: stimulus 11 DA DA BB AD 00 followed by the REQ-032 tail -> frame_valid, same frame_data as REQ-032.
REQ-035 Timeout, TIMEOUT_CYCLES=100: header plus 3 payload bytes, then 100 idle cycles -> timeout_error pulse in cycle 100; busy falls; the next valid frame is accepted.
REQ-036 Reset mid-frame: RST for 1 cycle after byte 6 of the REQ-032 frame, then resend the full frame -> no error pulses; exactly one frame_valid.
REQ-037 Back-to-back: two REQ-032 frames with strobes every cycle and no gap -> two frame_valid pulses, 15 cycles apart.
